// File: rtl/sram_port_arbiter_if.sv
// Signal bundle around the shared-port arbiter: inst requester, data requester and the
// downstream SRAM-like port. mem_rdata bypasses the arbiter and goes straight to both masters.
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    // Environment view: CPU requesters plus the bridge behind the shared port.
    modport master (
        output inst_req, inst_size, inst_addr,
        input  inst_addr_ok, inst_data_ok,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

    // Arbiter view.
    modport slave (
        input  inst_req, inst_size, inst_addr,
        output inst_addr_ok, inst_data_ok,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the instruction and data requesters; data wins ties,
// a stalled grant is locked until addr_ok, and an owner FIFO routes each data_ok back.
module sram_port_arbiter #(
    parameter int MAX_OUTST = 4
) (
    input logic               clk,
    input logic               resetn,
    sram_port_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } lock_state_e;

    lock_state_e          state_q, state_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [MAX_OUTST-1:0] owner_q;

    logic sel_data;
    logic granted_req;
    logic not_full;
    logic mem_req;
    logic push;
    logic pop;
    logic head_owner;

    // ---------------- lock FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- lock FSM: next state ----------------
    // A full FIFO suppresses mem_req, so an existing lock simply holds.
    always_comb begin
        state_d = state_q;
        if (mem_req && !bus.mem_addr_ok) begin
            state_d = sel_data ? ST_LOCK_DATA : ST_LOCK_INST;
        end else if (mem_req) begin
            state_d = ST_FREE;
        end
    end

    // ---------------- lock FSM: outputs (grant select and port mux) ----------------
    always_comb begin
        unique case (state_q)
            ST_LOCK_INST: sel_data = 1'b0;
            ST_LOCK_DATA: sel_data = 1'b1;
            default:      sel_data = bus.data_req;
        endcase
    end

    assign granted_req = sel_data ? bus.data_req : bus.inst_req;
    assign not_full    = (count_q != CNT_W'(MAX_OUTST));
    assign mem_req     = granted_req & not_full & resetn;

    always_comb begin
        bus.mem_req   = mem_req;
        bus.mem_wr    = sel_data ? bus.data_wr    : 1'b0;
        bus.mem_size  = sel_data ? bus.data_size  : bus.inst_size;
        bus.mem_wstrb = sel_data ? bus.data_wstrb : 4'b0000;
        bus.mem_addr  = sel_data ? bus.data_addr  : bus.inst_addr;
        bus.mem_wdata = sel_data ? bus.data_wdata : 32'h0000_0000;
    end

    assign push = mem_req & bus.mem_addr_ok;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign pop  = bus.mem_data_ok & (count_q != '0) & resetn;

    assign bus.inst_addr_ok = push & ~sel_data;
    assign bus.data_addr_ok = push &  sel_data;

    assign head_owner       = owner_q[rptr_q];
    assign bus.inst_data_ok = pop & ~head_owner;
    assign bus.data_data_ok = pop &  head_owner;

    // ---------------- owner FIFO bookkeeping ----------------
    always_comb begin
        wptr_d  = wptr_q + PTR_W'(push);
        rptr_d  = rptr_q + PTR_W'(pop);
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wptr_q] <= sel_data;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: per-cycle vector table plus an owner
// scoreboard for data_ok routing, and hand-written reset sequences.
module tb_sram_port_arbiter;

    logic clk;
    logic resetn;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(.MAX_OUTST(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ir;
        logic dr;
        logic dw;
        logic aok;
        logic dok;
        logic mreq;
        logic iaok;
        logic daok;
        logic sel;
    } vec_t;

    vec_t tbl[$];
    logic sb[$];
    int   n_tests;
    int   n_fail;
    int   n_inst;
    int   n_data;

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                                input logic aok, input logic dok, input logic mreq,
                                input logic iaok, input logic daok, input logic sel);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.aok = aok; v.dok = dok;
        v.mreq = mreq; v.iaok = iaok; v.daok = daok; v.sel = sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_payload();
        bus.inst_size  = 2'b10;
        bus.inst_addr  = 32'h0000_1000 + 32'(n_inst * 4);
        bus.data_size  = 2'b01;
        bus.data_wstrb = 4'b0110;
        bus.data_addr  = 32'h0008_0000 + 32'(n_data * 4);
        bus.data_wdata = 32'hD000_0000 + 32'(n_data);
    endtask

    task automatic step(input vec_t v, input string tag);
        logic exp_iok;
        logic exp_dok;
        @(negedge clk);
        bus.inst_req    = v.ir;
        bus.data_req    = v.dr;
        bus.data_wr     = v.dw;
        bus.mem_addr_ok = v.aok;
        bus.mem_data_ok = v.dok;
        drive_payload();
        #1;
        exp_iok = v.dok && (sb.size() > 0) && (sb[0] == 1'b0);
        exp_dok = v.dok && (sb.size() > 0) && (sb[0] == 1'b1);
        chk({tag, ".mem_req"},      32'(bus.mem_req),      32'(v.mreq));
        chk({tag, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(v.iaok));
        chk({tag, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(v.daok));
        chk({tag, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(exp_iok));
        chk({tag, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(exp_dok));
        if (v.mreq) begin
            chk({tag, ".mem_addr"},  bus.mem_addr,
                v.sel ? bus.data_addr : bus.inst_addr);
            chk({tag, ".mem_wr"},    32'(bus.mem_wr),    32'(v.sel & v.dw));
            chk({tag, ".mem_size"},  32'(bus.mem_size),  v.sel ? 32'h1 : 32'h2);
            chk({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), v.sel ? 32'h6 : 32'h0);
            chk({tag, ".mem_wdata"}, bus.mem_wdata,
                v.sel ? bus.data_wdata : 32'h0);
        end
        if (v.dok && sb.size() > 0) void'(sb.pop_front());
        if (v.iaok) begin sb.push_back(1'b0); n_inst++; end
        if (v.daok) begin sb.push_back(1'b1); n_data++; end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_req"},      32'(bus.mem_req),      32'h0);
        chk({tag, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'h0);
        chk({tag, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'h0);
        chk({tag, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'h0);
        chk({tag, ".data_data_ok"}, 32'(bus.data_data_ok), 32'h0);
    endtask

    task automatic idle_inputs();
        bus.inst_req    = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
    endtask

    vec_t I_ROW, D_ROW, DRAIN;

    initial begin
        n_tests = 0; n_fail = 0; n_inst = 0; n_data = 0;
        I_ROW = mk(1,0,0,1,0, 1,1,0,0);
        D_ROW = mk(0,1,0,1,0, 1,0,1,1);
        DRAIN = mk(0,0,0,0,1, 0,0,0,0);

        // tie-break, then drain
        tbl.push_back(mk(1,1,0,1,0, 1,0,1,1));
        tbl.push_back(I_ROW);
        tbl.push_back(DRAIN);
        tbl.push_back(DRAIN);
        // inst stalls 3 cycles, data request arrives during the lock
        tbl.push_back(mk(1,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,1,1,0,0, 1,0,0,0));
        tbl.push_back(mk(1,1,1,1,0, 1,1,0,0));
        tbl.push_back(mk(0,1,1,1,0, 1,0,1,1));
        tbl.push_back(DRAIN);
        tbl.push_back(DRAIN);
        // fill to MAX_OUTST, stall at full, one pop frees a slot next cycle
        for (int i = 0; i < 4; i++) tbl.push_back(I_ROW);
        tbl.push_back(mk(1,1,0,1,0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,1,1, 0,0,0,0));
        tbl.push_back(mk(1,1,0,1,0, 1,0,1,1));
        for (int i = 0; i < 4; i++) tbl.push_back(DRAIN);
        // interleaved owners answered in order
        tbl.push_back(I_ROW);
        tbl.push_back(D_ROW);
        tbl.push_back(I_ROW);
        for (int i = 0; i < 3; i++) tbl.push_back(DRAIN);
        // spurious response, then push+pop at count 2 proven by where full hits
        tbl.push_back(DRAIN);
        tbl.push_back(I_ROW);
        tbl.push_back(D_ROW);
        tbl.push_back(mk(1,0,0,1,1, 1,1,0,0));
        tbl.push_back(I_ROW);
        tbl.push_back(I_ROW);
        tbl.push_back(mk(1,0,0,1,0, 0,0,0,0));
        for (int i = 0; i < 5; i++) tbl.push_back(DRAIN);

        // outputs held at 0 in reset even with every input asserted
        resetn = 1'b0;
        drive_payload();
        bus.mem_rdata   = 32'hCAFE_F00D;
        bus.inst_req    = 1'b1;
        bus.data_req    = 1'b1;
        bus.data_wr     = 1'b1;
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // reset asserted mid-lock with two requests outstanding
        step(I_ROW, "ml0");
        step(D_ROW, "ml1");
        step(mk(1,0,0,0,0, 1,0,0,0), "ml2");
        @(negedge clk);
        bus.inst_req    = 1'b1;
        bus.data_req    = 1'b1;
        bus.mem_addr_ok = 1'b1;
        bus.mem_data_ok = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        sb.delete();
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;

        // no lock survives (data wins), count restarted at 0 (full after 4 pushes)
        step(mk(1,1,0,0,1, 1,0,0,1), "pr0");
        step(mk(1,1,0,1,0, 1,0,1,1), "pr1");
        step(I_ROW, "pr2");
        step(I_ROW, "pr3");
        step(I_ROW, "pr4");
        step(mk(1,0,0,1,0, 0,0,0,0), "pr5");
        for (int i = 0; i < 4; i++) step(DRAIN, $sformatf("pd%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
